// File: rtl/alu_rf_sequencer_pkg.sv
// Shared ALU op encoding and default widths for the register-file/ALU sequencer slice.
package alu_rf_sequencer_pkg;

  typedef enum logic [1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    AND = 2'b10,
    OR  = 2'b11
  } alu_op_e;

  localparam int ADDR_WIDTH_DEF = 5;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int ALU_LAT_DEF    = 1;
  localparam int CNT_WIDTH_DEF  = 16;

endpackage

// File: rtl/alu_rf_sequencer_if.sv
// Instruction, host-load and RF/ALU signals of the sequencer; master is the instruction/host/ALU side.
interface alu_rf_sequencer_if
  import alu_rf_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
);

  logic                  instr_valid_i;
  logic                  instr_ready_o;
  alu_op_e               instr_op_i;
  logic [ADDR_WIDTH-1:0] instr_src_a_i;
  logic [ADDR_WIDTH-1:0] instr_src_b_i;
  logic [ADDR_WIDTH-1:0] instr_dst_i;
  logic                  host_we_i;
  logic [ADDR_WIDTH-1:0] host_waddr_i;
  logic [DATA_WIDTH-1:0] host_wdata_i;
  logic                  host_ready_o;
  logic [ADDR_WIDTH-1:0] raddr_a_o;
  logic [ADDR_WIDTH-1:0] raddr_b_o;
  alu_op_e               op_o;
  logic [DATA_WIDTH-1:0] data_c_i;
  logic                  c_i;
  logic [ADDR_WIDTH-1:0] waddr_c_o;
  logic [DATA_WIDTH-1:0] wdata_c_o;
  logic                  we_c_o;
  logic                  carry_o;
  logic                  busy_o;
  logic [CNT_WIDTH-1:0]  retired_o;

  modport master (
    output instr_valid_i, instr_op_i, instr_src_a_i, instr_src_b_i, instr_dst_i,
           host_we_i, host_waddr_i, host_wdata_i, data_c_i, c_i,
    input  instr_ready_o, host_ready_o, raddr_a_o, raddr_b_o, op_o,
           waddr_c_o, wdata_c_o, we_c_o, carry_o, busy_o, retired_o
  );

  modport slave (
    input  instr_valid_i, instr_op_i, instr_src_a_i, instr_src_b_i, instr_dst_i,
           host_we_i, host_waddr_i, host_wdata_i, data_c_i, c_i,
    output instr_ready_o, host_ready_o, raddr_a_o, raddr_b_o, op_o,
           waddr_c_o, wdata_c_o, we_c_o, carry_o, busy_o, retired_o
  );

endinterface

// File: rtl/seq_hazard_check.sv
// Flags a read-after-write hazard when either source matches the destination of any in-flight result.
module seq_hazard_check
  import alu_rf_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DEPTH      = ALU_LAT_DEF + 1
) (
  input  logic [ADDR_WIDTH-1:0]            src_a,
  input  logic [ADDR_WIDTH-1:0]            src_b,
  input  logic [DEPTH-1:0]                 dst_valid,
  input  logic [DEPTH-1:0][ADDR_WIDTH-1:0] dst_vec,
  output logic                             hazard
);

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (dst_valid[i] && ((dst_vec[i] == src_a) || (dst_vec[i] == src_b))) begin
        hazard = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rf_sequencer.sv
// Issues 3-address instructions to the RF/ALU, tracks them through the ALU latency, writes results
// back and shares the single RF write port with host loads.
module alu_rf_sequencer
  import alu_rf_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ALU_LAT    = ALU_LAT_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input logic               clk,
  input logic               rst_n,
  alu_rf_sequencer_if.slave bus
);

  logic                               fire;
  logic                               hazard;
  logic [ALU_LAT-1:0]                 pipe_valid;
  logic [ALU_LAT-1:0][ADDR_WIDTH-1:0] pipe_dst;
  logic                               wb_valid;
  logic [ADDR_WIDTH-1:0]              wb_dst;
  logic [DATA_WIDTH-1:0]              wb_data;
  logic                               wb_carry;
  logic [ADDR_WIDTH-1:0]              last_a;
  logic [ADDR_WIDTH-1:0]              last_b;
  alu_op_e                            last_op;
  logic                               carry_q;
  logic [CNT_WIDTH-1:0]               retired_q;
  logic [ALU_LAT:0]                   flight_valid;
  logic [ALU_LAT:0][ADDR_WIDTH-1:0]   flight_dst;
  logic                               host_sel;

  // The writeback stage is included because the RF has no write-through bypass.
  assign flight_valid = {wb_valid, pipe_valid};
  assign flight_dst   = {wb_dst, pipe_dst};

  seq_hazard_check #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (ALU_LAT + 1)
  ) u_hazard (
    .src_a    (bus.instr_src_a_i),
    .src_b    (bus.instr_src_b_i),
    .dst_valid(flight_valid),
    .dst_vec  (flight_dst),
    .hazard   (hazard)
  );

  assign bus.instr_ready_o = ~hazard;
  assign fire              = bus.instr_valid_i & ~hazard;

  assign bus.raddr_a_o = fire ? bus.instr_src_a_i : last_a;
  assign bus.raddr_b_o = fire ? bus.instr_src_b_i : last_b;
  assign bus.op_o      = fire ? bus.instr_op_i    : last_op;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_a  <= '0;
      last_b  <= '0;
      last_op <= ADD;
    end else if (fire) begin
      last_a  <= bus.instr_src_a_i;
      last_b  <= bus.instr_src_b_i;
      last_op <= bus.instr_op_i;
    end
  end

  // The last pipeline stage lines up with the registered ALU result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_valid <= '0;
      pipe_dst   <= '0;
      wb_valid   <= 1'b0;
      wb_dst     <= '0;
      wb_data    <= '0;
      wb_carry   <= 1'b0;
    end else begin
      pipe_valid[0] <= fire;
      pipe_dst[0]   <= bus.instr_dst_i;
      for (int i = 1; i < ALU_LAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_dst[i]   <= pipe_dst[i-1];
      end
      wb_valid <= pipe_valid[ALU_LAT-1];
      if (pipe_valid[ALU_LAT-1]) begin
        wb_dst   <= pipe_dst[ALU_LAT-1];
        wb_data  <= bus.data_c_i;
        wb_carry <= bus.c_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      carry_q   <= 1'b0;
      retired_q <= '0;
    end else if (wb_valid) begin
      carry_q   <= wb_carry;
      retired_q <= retired_q + CNT_WIDTH'(1);
    end
  end

  // Writeback owns the write port; a host load only gets through when no result is pending.
  assign host_sel          = ~wb_valid & bus.host_we_i;
  assign bus.host_ready_o  = ~wb_valid;
  assign bus.we_c_o        = wb_valid | bus.host_we_i;
  assign bus.waddr_c_o     = host_sel ? bus.host_waddr_i : wb_dst;
  assign bus.wdata_c_o     = host_sel ? bus.host_wdata_i : wb_data;
  assign bus.carry_o       = carry_q;
  assign bus.retired_o     = retired_q;
  assign bus.busy_o        = (|pipe_valid) | wb_valid;

endmodule

// File: tb/tb_alu_rf_sequencer.sv
// Drives the sequencer against a behavioural register file and registered ALU, checking writes,
// stalls and status outputs against an architectural model of the register file.
module tb_alu_rf_sequencer;
  import alu_rf_sequencer_pkg::*;

  localparam int AW  = 5;
  localparam int DW  = 32;
  localparam int LAT = 1;
  localparam int CW  = 16;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  int            n_checks = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  logic [DW-1:0] rf_mem   [2**AW] = '{default: '0};
  logic [DW-1:0] model_rf [2**AW] = '{default: '0};
  logic [DW-1:0] alu_data;
  logic          alu_c;
  int            exp_retired = 0;
  logic          exp_carry   = 1'b0;
  wr_t           obs_q[$];
  wr_t           exp_q[$];

  alu_rf_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  alu_rf_sequencer #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .ALU_LAT   (LAT),
    .CNT_WIDTH (CW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ALU semantics: carry is the 33rd bit of the unsigned add, borrow for subtract, zero for logic ops.
  function automatic logic [DW:0] alu_ref(input alu_op_e op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (op)
      ADD:     return {1'b0, a} + {1'b0, b};
      SUB:     return {1'b0, a} - {1'b0, b};
      AND:     return {1'b0, a & b};
      default: return {1'b0, a | b};
    endcase
  endfunction

  // Environment: combinational-read register file and a single-cycle registered ALU.
  always @(posedge clk) begin
    if (bus.we_c_o === 1'b1) rf_mem[bus.waddr_c_o] <= bus.wdata_c_o;
    {alu_c, alu_data} <= alu_ref(bus.op_o, rf_mem[bus.raddr_a_o], rf_mem[bus.raddr_b_o]);
  end

  assign bus.data_c_i = alu_data;
  assign bus.c_i      = alu_c;

  always @(negedge clk) begin : write_monitor
    wr_t w;
    if (rst_n && bus.we_c_o === 1'b1) begin
      w.cyc  = cyc;
      w.addr = bus.waddr_c_o;
      w.data = bus.wdata_c_o;
      obs_q.push_back(w);
    end
  end

  task automatic host_load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int k = 0;
    bus.host_we_i    = 1'b1;
    bus.host_waddr_i = a;
    bus.host_wdata_i = d;
    @(negedge clk);
    while (bus.host_ready_o !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    n_checks++;
    if (k >= 20) begin n_fail++; $display("[TB] FAIL host_load_timeout addr=%0d ready=%0b required=1", a, bus.host_ready_o); end
    @(posedge clk); #1;
    bus.host_we_i = 1'b0;
    model_rf[a]   = d;
  endtask

  task automatic issue(input alu_op_e op, input logic [AW-1:0] a, input logic [AW-1:0] b,
                       input logic [AW-1:0] d, input bit track, output int acc_cyc, output int stalls);
    logic [DW:0] r;
    wr_t         w;
    bus.instr_valid_i = 1'b1;
    bus.instr_op_i    = op;
    bus.instr_src_a_i = a;
    bus.instr_src_b_i = b;
    bus.instr_dst_i   = d;
    stalls = 0;
    @(negedge clk);
    while (bus.instr_ready_o !== 1'b1 && stalls < 20) begin @(negedge clk); stalls++; end
    n_checks++;
    if (stalls >= 20) begin n_fail++; $display("[TB] FAIL issue_timeout dst=%0d ready=%0b required=1", d, bus.instr_ready_o); end
    n_checks++;
    if (bus.raddr_a_o !== a || bus.raddr_b_o !== b || bus.op_o !== op) begin
      n_fail++;
      $display("[TB] FAIL issue_drive got a=%0d b=%0d op=%0d required a=%0d b=%0d op=%0d",
               bus.raddr_a_o, bus.raddr_b_o, bus.op_o, a, b, op);
    end
    acc_cyc = cyc;
    @(posedge clk); #1;
    bus.instr_valid_i = 1'b0;
    if (track) begin
      r           = alu_ref(op, model_rf[a], model_rf[b]);
      model_rf[d] = r[DW-1:0];
      exp_carry   = r[DW];
      exp_retired++;
      w.cyc  = acc_cyc + LAT + 1;
      w.addr = d;
      w.data = r[DW-1:0];
      exp_q.push_back(w);
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while (bus.busy_o !== 1'b0 && k < 40) begin @(negedge clk); k++; end
    n_checks++;
    if (k >= 40) begin n_fail++; $display("[TB] FAIL idle_timeout busy=%0b required=0", bus.busy_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bus.instr_valid_i = 1'b0;
    bus.instr_op_i    = ADD;
    bus.instr_src_a_i = '0;
    bus.instr_src_b_i = '0;
    bus.instr_dst_i   = '0;
    bus.host_we_i     = 1'b0;
    bus.host_waddr_i  = '0;
    bus.host_wdata_i  = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus.we_c_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_we got=%0b required=0", bus.we_c_o); end
    n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy got=%0b required=0", bus.busy_o); end
    n_checks++; if (bus.retired_o !== '0) begin n_fail++; $display("[TB] FAIL reset_retired got=%0d required=0", bus.retired_o); end
    n_checks++; if (bus.carry_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_carry got=%0b required=0", bus.carry_o); end
    n_checks++; if (bus.raddr_a_o !== '0 || bus.raddr_b_o !== '0 || bus.op_o !== ADD) begin
      n_fail++; $display("[TB] FAIL reset_raddr got a=%0d b=%0d op=%0d required 0 0 0", bus.raddr_a_o, bus.raddr_b_o, bus.op_o); end
    n_checks++; if (bus.waddr_c_o !== '0 || bus.wdata_c_o !== '0) begin
      n_fail++; $display("[TB] FAIL reset_wport got addr=%0d data=%h required 0 0", bus.waddr_c_o, bus.wdata_c_o); end
    n_checks++; if (bus.host_ready_o !== 1'b1 || bus.instr_ready_o !== 1'b1) begin
      n_fail++; $display("[TB] FAIL reset_ready got host=%0b instr=%0b required 1 1", bus.host_ready_o, bus.instr_ready_o); end
    @(posedge clk); #1;
    rst_n       = 1'b1;
    exp_retired = 0;
    exp_carry   = 1'b0;
  endtask

  task automatic test_add();
    int t, s;
    host_load(5'd1, 32'd5);
    host_load(5'd2, 32'd7);
    issue(ADD, 5'd1, 5'd2, 5'd3, 1'b1, t, s);
    @(negedge clk);
    n_checks++; if (bus.we_c_o !== 1'b0 || bus.busy_o !== 1'b1) begin
      n_fail++; $display("[TB] FAIL add_t1 got we=%0b busy=%0b required we=0 busy=1", bus.we_c_o, bus.busy_o); end
    @(negedge clk);
    n_checks++; if (bus.we_c_o !== 1'b1 || bus.waddr_c_o !== 5'd3 || bus.wdata_c_o !== 32'd12) begin
      n_fail++; $display("[TB] FAIL add_write got we=%0b addr=%0d data=%0d required we=1 addr=3 data=12",
                         bus.we_c_o, bus.waddr_c_o, bus.wdata_c_o); end
    @(negedge clk);
    n_checks++; if (bus.retired_o !== 16'd1 || bus.we_c_o !== 1'b0 || bus.busy_o !== 1'b0) begin
      n_fail++; $display("[TB] FAIL add_retire got retired=%0d we=%0b busy=%0b required 1 0 0",
                         bus.retired_o, bus.we_c_o, bus.busy_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_raw();
    int t1, s1, t2, s2;
    host_load(5'd3, 32'd100);
    issue(ADD, 5'd1, 5'd2, 5'd3, 1'b1, t1, s1);
    issue(SUB, 5'd3, 5'd1, 5'd4, 1'b1, t2, s2);
    wait_idle();
    n_checks++; if (s2 != 2 || t2 != t1 + 3) begin
      n_fail++; $display("[TB] FAIL raw_stall got stalls=%0d gap=%0d required stalls=2 gap=3", s2, t2 - t1); end
    n_checks++; if (rf_mem[4] !== 32'd7 || rf_mem[3] !== 32'd12) begin
      n_fail++; $display("[TB] FAIL raw_result got r3=%0d r4=%0d required r3=12 r4=7", rf_mem[3], rf_mem[4]); end
    n_checks++; if (bus.retired_o !== CW'(exp_retired)) begin
      n_fail++; $display("[TB] FAIL raw_retired got=%0d required=%0d", bus.retired_o, exp_retired); end
  endtask

  task automatic test_carry();
    int t, s;
    host_load(5'd5, 32'hFFFF_FFFF);
    host_load(5'd6, 32'd1);
    issue(ADD, 5'd5, 5'd6, 5'd7, 1'b1, t, s);
    wait_idle();
    n_checks++; if (bus.carry_o !== 1'b1 || rf_mem[7] !== 32'd0) begin
      n_fail++; $display("[TB] FAIL carry_set got carry=%0b r7=%h required carry=1 r7=0", bus.carry_o, rf_mem[7]); end
    issue(ADD, 5'd1, 5'd1, 5'd8, 1'b1, t, s);
    wait_idle();
    n_checks++; if (bus.carry_o !== 1'b0 || rf_mem[8] !== 32'd10) begin
      n_fail++; $display("[TB] FAIL carry_clear got carry=%0b r8=%0d required carry=0 r8=10", bus.carry_o, rf_mem[8]); end
  endtask

  task automatic test_host_collision();
    int t, s;
    issue(ADD, 5'd1, 5'd2, 5'd9, 1'b1, t, s);
    @(posedge clk); #1;
    bus.host_we_i    = 1'b1;
    bus.host_waddr_i = 5'd10;
    bus.host_wdata_i = 32'h1234;
    @(negedge clk);
    n_checks++; if (bus.host_ready_o !== 1'b0 || bus.we_c_o !== 1'b1 || bus.waddr_c_o !== 5'd9 || bus.wdata_c_o !== 32'd12) begin
      n_fail++; $display("[TB] FAIL collide_wb got hready=%0b we=%0b addr=%0d data=%h required 0 1 9 0000000c",
                         bus.host_ready_o, bus.we_c_o, bus.waddr_c_o, bus.wdata_c_o); end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (bus.host_ready_o !== 1'b1 || bus.we_c_o !== 1'b1 || bus.waddr_c_o !== 5'd10 || bus.wdata_c_o !== 32'h1234) begin
      n_fail++; $display("[TB] FAIL collide_host got hready=%0b we=%0b addr=%0d data=%h required 1 1 10 00001234",
                         bus.host_ready_o, bus.we_c_o, bus.waddr_c_o, bus.wdata_c_o); end
    @(posedge clk); #1;
    bus.host_we_i = 1'b0;
    model_rf[10]  = 32'h1234;
    wait_idle();
    n_checks++; if (rf_mem[9] !== 32'd12 || rf_mem[10] !== 32'h1234) begin
      n_fail++; $display("[TB] FAIL collide_rf got r9=%h r10=%h required 0000000c 00001234", rf_mem[9], rf_mem[10]); end
  endtask

  task automatic test_back_to_back();
    int            t[4];
    int            s[4];
    alu_op_e       ops[4]  = '{ADD, SUB, AND, OR};
    logic [DW-1:0] vals[4] = '{32'd12, 32'hFFFF_FFFE, 32'd5, 32'd7};
    obs_q.delete();
    for (int i = 0; i < 4; i++) issue(ops[i], 5'd1, 5'd2, 5'(11 + i), 1'b1, t[i], s[i]);
    wait_idle();
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (s[i] != 0 || t[i] != t[0] + i) begin
        n_fail++; $display("[TB] FAIL b2b_issue%0d got stalls=%0d offset=%0d required 0 %0d", i, s[i], t[i] - t[0], i); end
    end
    n_checks++;
    if (obs_q.size() != 4) begin
      n_fail++; $display("[TB] FAIL b2b_count got=%0d required=4", obs_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (obs_q[i].cyc != t[0] + i + 2 || obs_q[i].addr !== 5'(11 + i) || obs_q[i].data !== vals[i]) begin
          n_fail++; $display("[TB] FAIL b2b_write%0d got cyc=%0d addr=%0d data=%h required cyc=%0d addr=%0d data=%h",
                             i, obs_q[i].cyc, obs_q[i].addr, obs_q[i].data, t[0] + i + 2, 11 + i, vals[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int t, s;
    issue(ADD, 5'd1, 5'd2, 5'd15, 1'b0, t, s);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n       = 1'b1;
    exp_retired = 0;
    exp_carry   = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.we_c_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.retired_o !== '0 || bus.carry_o !== 1'b0) begin
      n_fail++; $display("[TB] FAIL rstmid_state got we=%0b busy=%0b retired=%0d carry=%0b required all 0",
                         bus.we_c_o, bus.busy_o, bus.retired_o, bus.carry_o); end
    @(negedge clk);
    n_checks++; if (bus.we_c_o !== 1'b0 || rf_mem[15] !== 32'd0) begin
      n_fail++; $display("[TB] FAIL rstmid_nowrite got we=%0b r15=%h required we=0 r15=0", bus.we_c_o, rf_mem[15]); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int t, s;
    obs_q.delete();
    exp_q.delete();
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      issue(alu_op_e'($urandom_range(0, 3)), 5'($urandom_range(1, 6)), 5'($urandom_range(1, 6)),
            5'($urandom_range(1, 6)), 1'b1, t, s);
    end
    wait_idle();
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("[TB] FAIL rand_count got=%0d required=%0d", obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_checks++;
        if (obs_q[i].cyc != exp_q[i].cyc || obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data) begin
          n_fail++; $display("[TB] FAIL rand_write%0d got cyc=%0d addr=%0d data=%h required cyc=%0d addr=%0d data=%h",
                             i, obs_q[i].cyc, obs_q[i].addr, obs_q[i].data, exp_q[i].cyc, exp_q[i].addr, exp_q[i].data);
        end
      end
    end
    for (int r = 0; r < 2**AW; r++) begin
      n_checks++; if (rf_mem[r] !== model_rf[r]) begin
        n_fail++; $display("[TB] FAIL rand_rf%0d got=%h required=%h", r, rf_mem[r], model_rf[r]); end
    end
    n_checks++; if (bus.retired_o !== CW'(exp_retired) || bus.carry_o !== exp_carry) begin
      n_fail++; $display("[TB] FAIL rand_status got retired=%0d carry=%0b required retired=%0d carry=%0b",
                         bus.retired_o, bus.carry_o, exp_retired, exp_carry); end
  endtask

  initial begin
    $display("[TB] starting alu_rf_sequencer bench");
    test_reset();
    test_add();
    test_raw();
    test_carry();
    test_host_collision();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
